// File: rtl/rtl_sbc_pkg.sv
// Shared constants for the CPU-bus peripheral blocks.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rtl_sbc_pkg;

  // Width of the 6502 data bus.
  localparam int BUS_DATA_W = 8;

  // Level of the CPU RW line during each kind of bus cycle.
  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/rtl_sync_fifo.sv
// Synchronous FIFO: registered storage, head entry always visible on dout.
// Latency: a push shows on empty/level the cycle after it is accepted; no bypass.
// Backpressure: push is dropped when full unless a pop happens in the same cycle.
module rtl_sync_fifo #(
  parameter int WIDTH      = 10,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [WIDTH-1:0]      din,
  input  logic                  pop,
  output logic [WIDTH-1:0]      dout,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]    mem [DEPTH];
  // One extra pointer bit tells full (MSBs differ) from empty (MSBs equal).
  logic [DEPTH_LOG2:0] wr_ptr;
  logic [DEPTH_LOG2:0] rd_ptr;
  logic                do_push;
  logic                do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]) &&
                 (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]);
  assign level = wr_ptr - rd_ptr;

  // A pop at full frees the slot the push is about to fill.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign dout = mem[rd_ptr[DEPTH_LOG2-1:0]];

  // Pointer update; wrap is implicit in the DEPTH_LOG2+1 bit arithmetic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage is cleared so the head reads as zero straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push) begin
      mem[wr_ptr[DEPTH_LOG2-1:0]] <= din;
    end
  end

endmodule

// File: rtl/rtl_bus_write_receiver.sv
// Oversamples the async 6502 bus, captures selected write cycles into a FIFO.
// Latency: push visible on M_VALID/LEVEL 3 CLK after PHI2 falls (sampling + edge detect + push).
// Backpressure: M_VALID/M_READY drain; a write arriving while full is dropped and sets sticky OVF.
module rtl_bus_write_receiver
  import rtl_sbc_pkg::*;
#(
  parameter int ADDR_W     = 2,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  PHI2,
  input  logic                  CS_N,
  input  logic                  RW,
  input  logic [ADDR_W-1:0]     A,
  input  logic [BUS_DATA_W-1:0] D,
  output logic [BUS_DATA_W-1:0] M_DATA,
  output logic [ADDR_W-1:0]     M_ADDR,
  output logic                  M_VALID,
  input  logic                  M_READY,
  output logic [DEPTH_LOG2:0]   LEVEL,
  output logic                  OVF,
  input  logic                  OVF_CLR
);

  localparam int ENTRY_W = ADDR_W + BUS_DATA_W;

  typedef struct packed {
    logic                  phi2;
    logic                  cs_n;
    logic                  rw;
    logic [ADDR_W-1:0]     a;
    logic [BUS_DATA_W-1:0] d;
  } smp_t;

  smp_t               bus_now;
  smp_t               s1;
  smp_t               s2;
  smp_t               s3;
  // v1/v2 mark stages that hold real samples taken since reset release.
  logic               v1;
  logic               v2;
  // armed goes high once a genuine PHI2-low sample has been seen, so the
  // PHI2 cycle that was in flight across reset can never commit.
  logic               armed;
  logic               phi2_fall;
  logic               commit;
  logic [ENTRY_W-1:0] payload;
  logic [ENTRY_W-1:0] head;
  logic               fifo_full;
  logic               fifo_empty;
  logic               pop;

  assign bus_now = {PHI2, CS_N, RW, A, D};

  // Three-stage sample pipeline; s1 only absorbs metastability.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else begin
      s1 <= bus_now;
      s2 <= s1;
      s3 <= s2;
      v1 <= 1'b1;
      v2 <= v1;
    end
  end

  // Arm the detector on the first real low PHI2 after reset.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      armed <= 1'b0;
    end else if (v2 && !s2.phi2) begin
      armed <= 1'b1;
    end
  end

  // A single high-to-low transition between s3 and s2 gives one commit per
  // PHI2 cycle, however short the high phase was.
  assign phi2_fall = s3.phi2 & ~s2.phi2;
  assign commit    = armed & phi2_fall & ~s3.cs_n & (s3.rw == RW_WRITE);
  // s3 is the last sample taken while PHI2 was still high.
  assign payload   = {s3.a, s3.d};

  assign M_VALID = ~fifo_empty;
  assign pop     = M_VALID & M_READY;

  rtl_sync_fifo #(
    .WIDTH      (ENTRY_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (RST_N),
    .push  (commit),
    .din   (payload),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (LEVEL)
  );

  assign {M_ADDR, M_DATA} = head;

  // Sticky overflow: a dropped commit sets it, and wins over a same-cycle clear.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      OVF <= 1'b0;
    end else if (commit && fifo_full && !pop) begin
      OVF <= 1'b1;
    end else if (OVF_CLR) begin
      OVF <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rtl_bus_write_receiver.sv
// Bench for rtl_bus_write_receiver: scenario tasks plus a pop-side scoreboard.
// Latency: n/a.
// Backpressure: M_READY driven per scenario (held low, pulsed, or random).
module tb_rtl_bus_write_receiver;
  import rtl_sbc_pkg::*;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       PHI2 = 1'b0;
  logic       CS_N = 1'b1;
  logic       RW = 1'b1;
  logic [1:0] A = '0;
  logic [7:0] D = '0;
  logic [7:0] M_DATA;
  logic [1:0] M_ADDR;
  logic       M_VALID;
  logic       M_READY = 1'b0;
  logic [2:0] LEVEL;
  logic       OVF;
  logic       OVF_CLR = 1'b0;

  int         checks = 0;
  int         errors = 0;
  logic [9:0] sb[$];
  bit         ovf_seen = 1'b0;

  rtl_bus_write_receiver #(.ADDR_W(2), .DEPTH_LOG2(2)) dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .PHI2    (PHI2),
    .CS_N    (CS_N),
    .RW      (RW),
    .A       (A),
    .D       (D),
    .M_DATA  (M_DATA),
    .M_ADDR  (M_ADDR),
    .M_VALID (M_VALID),
    .M_READY (M_READY),
    .LEVEL   (LEVEL),
    .OVF     (OVF),
    .OVF_CLR (OVF_CLR)
  );

  always #5 CLK = ~CLK;

  // Pop-side scoreboard: sampled mid-low-phase, ahead of the edge that pops.
  initial begin
    logic [9:0] got;
    logic [9:0] exp;
    forever begin
      @(negedge CLK);
      #2;
      if (M_VALID && M_READY) begin
        checks++;
        if (OVF) ovf_seen = 1'b1;
        got = {M_ADDR, M_DATA};
        if (ovf_seen)
          while (sb.size() > 0 && sb[0] !== got) void'(sb.pop_front());
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL pop_unexpected got=%h expected none", got);
        end else begin
          exp = sb.pop_front();
          if (got !== exp) begin
            errors++;
            $display("FAIL pop_order got=%h expected=%h", got, exp);
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // One full PHI2 cycle with `half` CLK periods per phase.
  task automatic bus_cycle(input logic cs_n, input logic rw, input logic [1:0] a,
                           input logic [7:0] d, input int half, input bit exp);
    A = a; D = d; CS_N = cs_n; RW = rw; PHI2 = 1'b1;
    tick(half);
    PHI2 = 1'b0;
    if (exp) sb.push_back({a, d});
    tick(half);
  endtask

  task automatic test_reset();
    tick(2);
    checks++; if (M_VALID !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b expected=0", M_VALID); end
    checks++; if (LEVEL !== 3'd0) begin errors++; $display("FAIL rst_level got=%0d expected=0", LEVEL); end
    checks++; if (OVF !== 1'b0) begin errors++; $display("FAIL rst_ovf got=%b expected=0", OVF); end
    checks++; if ({M_ADDR, M_DATA} !== 10'h0) begin errors++; $display("FAIL rst_head got=%h expected=000", {M_ADDR, M_DATA}); end
    RST_N = 1'b1;
    tick(3);
    bus_cycle(1'b0, RW_WRITE, 2'd1, 8'hC1, 4, 1'b1);
    bus_cycle(1'b0, RW_WRITE, 2'd2, 8'hC2, 4, 1'b1);
    tick(1);
    checks++; if (LEVEL !== 3'd2) begin errors++; $display("FAIL pre_rst_level got=%0d expected=2", LEVEL); end
    // Reset in the middle of a selected write's high phase.
    A = 2'd3; D = 8'h5A; CS_N = 1'b0; RW = RW_WRITE; PHI2 = 1'b1;
    tick(2);
    RST_N = 1'b0;
    @(posedge CLK); #1;
    checks++; if (M_VALID !== 1'b0 || LEVEL !== 3'd0 || OVF !== 1'b0)
      begin errors++; $display("FAIL mid_rst got v=%b l=%0d o=%b expected 0 0 0", M_VALID, LEVEL, OVF); end
    sb.delete();
    @(negedge CLK);
    RST_N = 1'b1;
    tick(2);
    PHI2 = 1'b0;
    tick(8);
    checks++; if (LEVEL !== 3'd0 || M_VALID !== 1'b0)
      begin errors++; $display("FAIL rst_no_commit got l=%0d v=%b expected 0 0", LEVEL, M_VALID); end
  endtask

  task automatic test_single();
    bus_cycle(1'b0, RW_WRITE, 2'd2, 8'hA5, 4, 1'b1);
    checks++; if (M_VALID !== 1'b1 || LEVEL !== 3'd1)
      begin errors++; $display("FAIL single_vld got v=%b l=%0d expected 1 1", M_VALID, LEVEL); end
    checks++; if (M_ADDR !== 2'd2 || M_DATA !== 8'hA5)
      begin errors++; $display("FAIL single_head got %0d/%h expected 2/a5", M_ADDR, M_DATA); end
    M_READY = 1'b1;
    tick(1);
    M_READY = 1'b0;
    #1;
    checks++; if (LEVEL !== 3'd0 || M_VALID !== 1'b0)
      begin errors++; $display("FAIL single_pop got l=%0d v=%b expected 0 0", LEVEL, M_VALID); end
  endtask

  task automatic test_filter();
    M_READY = 1'b1;
    bus_cycle(1'b0, RW_READ, 2'd1, 8'h3C, 4, 1'b0);
    bus_cycle(1'b1, RW_WRITE, 2'd3, 8'h77, 4, 1'b0);
    tick(2);
    M_READY = 1'b0;
    checks++; if (LEVEL !== 3'd0 || M_VALID !== 1'b0)
      begin errors++; $display("FAIL filter got l=%0d v=%b expected 0 0", LEVEL, M_VALID); end
  endtask

  task automatic test_order();
    logic [7:0] dv;
    for (int i = 0; i < 4; i++) begin
      dv = 8'(8'h11 * (i + 1));
      bus_cycle(1'b0, RW_WRITE, 2'(i), dv, 4, 1'b1);
    end
    tick(1);
    checks++; if (LEVEL !== 3'd4 || OVF !== 1'b0)
      begin errors++; $display("FAIL order_full got l=%0d o=%b expected 4 0", LEVEL, OVF); end
    for (int i = 0; i < 3; i++) begin
      tick(1);
      checks++; if (M_DATA !== 8'h11 || M_ADDR !== 2'd0)
        begin errors++; $display("FAIL stall_head got %0d/%h expected 0/11", M_ADDR, M_DATA); end
    end
    M_READY = 1'b1;
    tick(4);
    M_READY = 1'b0;
    #1;
    checks++; if (LEVEL !== 3'd0 || sb.size() != 0)
      begin errors++; $display("FAIL order_drain got l=%0d left=%0d expected 0 0", LEVEL, sb.size()); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 5; i++)
      bus_cycle(1'b0, RW_WRITE, 2'(i), 8'(8'hA1 + i), 4, (i < 4));
    tick(1);
    checks++; if (OVF !== 1'b1 || LEVEL !== 3'd4)
      begin errors++; $display("FAIL ovf_set got o=%b l=%0d expected 1 4", OVF, LEVEL); end
    checks++; if (M_DATA !== 8'hA1 || M_ADDR !== 2'd0)
      begin errors++; $display("FAIL ovf_head got %0d/%h expected 0/a1", M_ADDR, M_DATA); end
    OVF_CLR = 1'b1;
    tick(1);
    OVF_CLR = 1'b0;
    #1;
    checks++; if (OVF !== 1'b0) begin errors++; $display("FAIL ovf_clr got=%b expected=0", OVF); end
    // Write whose push lands on the same edge as a pop at full.
    A = 2'd2; D = 8'hE7; CS_N = 1'b0; RW = RW_WRITE; PHI2 = 1'b1;
    tick(4);
    PHI2 = 1'b0;
    sb.push_back({2'd2, 8'hE7});
    tick(2);
    M_READY = 1'b1;
    tick(1);
    M_READY = 1'b0;
    tick(2);
    checks++; if (OVF !== 1'b0 || LEVEL !== 3'd4)
      begin errors++; $display("FAIL push_pop_full got o=%b l=%0d expected 0 4", OVF, LEVEL); end
    M_READY = 1'b1;
    tick(5);
    M_READY = 1'b0;
    #1;
    checks++; if (LEVEL !== 3'd0 || sb.size() != 0)
      begin errors++; $display("FAIL ovf_drain got l=%0d left=%0d expected 0 0", LEVEL, sb.size()); end
  endtask

  task automatic test_back_to_back();
    bit done = 1'b0;
    ovf_seen = 1'b0;
    fork
      begin
        logic [1:0] ra;
        logic [7:0] rd;
        for (int i = 0; i < 16; i++) begin
          ra = 2'($urandom_range(0, 3));
          rd = 8'($urandom_range(0, 255));
          bus_cycle(1'b0, RW_WRITE, ra, rd, 2, 1'b1);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(negedge CLK);
          M_READY = ($urandom_range(0, 3) != 0);
        end
      end
    join
    M_READY = 1'b1;
    tick(8);
    M_READY = 1'b0;
    #1;
    checks++; if (LEVEL !== 3'd0) begin errors++; $display("FAIL b2b_level got=%0d expected=0", LEVEL); end
    checks++; if (sb.size() != 0 && !ovf_seen)
      begin errors++; $display("FAIL b2b_lost got left=%0d expected 0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_filter();
    test_order();
    test_overflow();
    test_back_to_back();
    tick(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
